// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer: EX-stage controller for the M-extension units.
// Issues work to a fixed-latency pipelined multiplier or an iterative divider,
// stalls the front end while an operation is outstanding, resolves divide-by-zero
// and signed overflow locally, and presents the 32-bit result for one cycle.
//
// Handshake: an M-op is accepted in the cycle where state is IDLE, ex_valid and
// ex_muldiv are high and kill is low (the issue cycle). stall is held high from
// the issue cycle until the result is captured. result_valid is high for exactly
// one cycle (DONE) with stall low, and the EX stage consumes the result in that
// cycle. kill overrides everything: it drops stall/result_valid in the same
// cycle and returns the sequencer to IDLE.
module muldiv_sequencer #(
    parameter int MUL_LATENCY = 2  // legal range 1..15
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ex_valid,
    input  logic        ex_muldiv,
    input  logic [2:0]  ex_funct3,
    input  logic [31:0] ex_rs1_val,
    input  logic [31:0] ex_rs2_val,
    input  logic        kill,
    input  logic [63:0] mul_product,
    input  logic        div_done,
    input  logic [31:0] div_quotient,
    input  logic [31:0] div_remainder,
    output logic        mul_start,
    output logic        mul_a_signed,
    output logic        mul_b_signed,
    output logic        div_start,
    output logic        div_signed,
    output logic        div_abort,
    output logic        stall,
    output logic [31:0] result,
    output logic        result_valid,
    output logic [1:0]  dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_MUL_WAIT = 2'd1,
        S_DIV_WAIT = 2'd2,
        S_DONE     = 2'd3
    } state_t;

    // Counter is loaded so that it reaches zero in the cycle mul_product is valid.
    localparam logic [3:0] CNT_LOAD = 4'(MUL_LATENCY - 1);

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] result_q, result_d;
    logic [2:0]  funct3_q, funct3_d;

    logic issue;
    logic is_div_op;
    logic div_by_zero;
    logic signed_ovf;
    logic fast_path;

    // Issue decode and the two divide cases answered without the divider.
    always_comb begin
        issue       = (state_q == S_IDLE) & ex_valid & ex_muldiv & ~kill;
        is_div_op   = ex_funct3[2];
        div_by_zero = (ex_rs2_val == 32'd0);
        // Only DIV/REM (funct3[0] = 0) are signed and can overflow.
        signed_ovf  = ~ex_funct3[0] & (ex_rs1_val == 32'h8000_0000)
                      & (ex_rs2_val == 32'hFFFF_FFFF);
        fast_path   = is_div_op & (div_by_zero | signed_ovf);
    end

    // Next-state, counter, latched funct3 and result capture.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        funct3_d = funct3_q;
        if (kill) begin
            state_d = S_IDLE;
            cnt_d   = 4'd0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (issue) begin
                        funct3_d = ex_funct3;
                        if (!is_div_op) begin
                            cnt_d   = CNT_LOAD;
                            state_d = S_MUL_WAIT;
                        end else if (fast_path) begin
                            state_d = S_DONE;
                            if (div_by_zero) begin
                                // REM/REMU return the dividend, DIV/DIVU all ones.
                                result_d = ex_funct3[1] ? ex_rs1_val : 32'hFFFF_FFFF;
                            end else begin
                                result_d = ex_funct3[1] ? 32'd0 : 32'h8000_0000;
                            end
                        end else begin
                            state_d = S_DIV_WAIT;
                        end
                    end
                end
                S_MUL_WAIT: begin
                    if (cnt_q == 4'd0) begin
                        // MUL takes the low word; MULH/MULHSU/MULHU the high word.
                        result_d = (funct3_q[1:0] == 2'b00) ? mul_product[31:0]
                                                            : mul_product[63:32];
                        state_d  = S_DONE;
                    end else begin
                        cnt_d = cnt_q - 4'd1;
                    end
                end
                S_DIV_WAIT: begin
                    if (div_done) begin
                        result_d = funct3_q[1] ? div_remainder : div_quotient;
                        state_d  = S_DONE;
                    end
                end
                S_DONE: begin
                    state_d = S_IDLE;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    // Unit controls and pipeline handshake; combinational so the issue cycle
    // and kill take effect in the same cycle they occur.
    always_comb begin
        mul_start    = issue & ~is_div_op;
        mul_a_signed = mul_start & ((ex_funct3 == 3'b001) | (ex_funct3 == 3'b010));
        mul_b_signed = mul_start & (ex_funct3 == 3'b001);
        div_start    = issue & is_div_op & ~fast_path;
        div_signed   = div_start & ~ex_funct3[0];
        div_abort    = kill & (state_q == S_DIV_WAIT);
        stall        = ~kill & (issue | (state_q == S_MUL_WAIT) | (state_q == S_DIV_WAIT));
        result_valid = ~kill & (state_q == S_DONE);
        result       = result_q;
        dbg_state    = state_q;
    end

    // State register; async reset returns to IDLE with a cleared result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            cnt_q    <= 4'd0;
            result_q <= 32'd0;
            funct3_q <= 3'd0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            funct3_q <= funct3_d;
        end
    end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// tb_muldiv_sequencer: randomized and directed bench for muldiv_sequencer with a
// delayed multiplier model, a scripted divider and an arithmetic reference model.
module tb_muldiv_sequencer;

    localparam int MUL_L  = 2;
    localparam int BUDGET = 200;

    logic        clk;
    logic        rst_n;
    logic        ex_valid;
    logic        ex_muldiv;
    logic [2:0]  ex_funct3;
    logic [31:0] ex_rs1_val;
    logic [31:0] ex_rs2_val;
    logic        kill;
    logic [63:0] mul_product;
    logic        div_done;
    logic [31:0] div_quotient;
    logic [31:0] div_remainder;
    logic        mul_start;
    logic        mul_a_signed;
    logic        mul_b_signed;
    logic        div_start;
    logic        div_signed;
    logic        div_abort;
    logic        stall;
    logic [31:0] result;
    logic        result_valid;
    logic [1:0]  dbg_state;

    int n_checks;
    int n_fail;

    muldiv_sequencer #(.MUL_LATENCY(MUL_L)) dut (
        .clk(clk), .rst_n(rst_n), .ex_valid(ex_valid), .ex_muldiv(ex_muldiv),
        .ex_funct3(ex_funct3), .ex_rs1_val(ex_rs1_val), .ex_rs2_val(ex_rs2_val),
        .kill(kill), .mul_product(mul_product), .div_done(div_done),
        .div_quotient(div_quotient), .div_remainder(div_remainder),
        .mul_start(mul_start), .mul_a_signed(mul_a_signed), .mul_b_signed(mul_b_signed),
        .div_start(div_start), .div_signed(div_signed), .div_abort(div_abort),
        .stall(stall), .result(result), .result_valid(result_valid), .dbg_state(dbg_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Multiplier model: product of the operands seen with mul_start appears MUL_L cycles later.
    function automatic logic [63:0] mul_unit(input logic [31:0] a, input logic [31:0] b,
                                             input logic sa, input logic sb);
        logic [63:0] ea, eb;
        ea = sa ? {{32{a[31]}}, a} : {32'd0, a};
        eb = sb ? {{32{b[31]}}, b} : {32'd0, b};
        return ea * eb;
    endfunction

    logic [63:0] mul_pipe [MUL_L];
    always @(posedge clk) begin
        if (mul_start) mul_pipe[0] <= mul_unit(ex_rs1_val, ex_rs2_val, mul_a_signed, mul_b_signed);
        for (int i = 1; i < MUL_L; i++) mul_pipe[i] <= mul_pipe[i-1];
    end
    assign mul_product = mul_pipe[MUL_L-1];

    // Reference model: RISC-V M-extension results from funct3 and operands.
    function automatic logic [31:0] ref_result(input logic [2:0] f3, input logic [31:0] a,
                                               input logic [31:0] b);
        longint sa, sb, ua, ub, p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'({32'd0, a});
        ub = longint'({32'd0, b});
        p  = 0;
        case (f3)
            3'd0: begin p = sa * sb; return p[31:0]; end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * ub; return p[63:32]; end
            3'd3: begin p = ua * ub; return p[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
                p = sa / sb; return p[31:0];
            end
            3'd5: begin if (b == 0) return 32'hFFFF_FFFF; return a / b; end
            3'd6: begin
                if (b == 0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
                p = sa % sb; return p[31:0];
            end
            default: begin if (b == 0) return a; return a % b; end
        endcase
    endfunction

    function automatic int ref_latency(input logic [2:0] f3, input logic [31:0] a,
                                       input logic [31:0] b, input int div_lat);
        if (!f3[2]) return MUL_L + 1;
        if (b == 0) return 1;
        if (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
        return div_lat + 1;
    endfunction

    // Driver: present one M-op at the current cycle, act as the divider, observe.
    task automatic run_mop(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                           input int div_lat, output int stall_n, output int rv_at,
                           output logic [31:0] res, output int extra_starts,
                           output logic t_mul, output logic t_div, output logic t_as,
                           output logic t_bs, output logic t_ds, output logic rv_stall);
        logic [31:0] q, r;
        logic        got_div;
        stall_n = 0; rv_at = -1; res = 32'd0; extra_starts = 0; rv_stall = 1'b0;
        q = 32'd0; r = 32'd0;
        ex_valid = 1'b1; ex_muldiv = 1'b1; ex_funct3 = f3; ex_rs1_val = a; ex_rs2_val = b;
        // a stray div_done in the issue cycle must be ignored
        div_done = 1'b1; div_quotient = $urandom; div_remainder = $urandom;
        @(negedge clk);
        t_mul = mul_start; t_div = div_start; t_as = mul_a_signed; t_bs = mul_b_signed;
        t_ds = div_signed;
        if (stall) stall_n++;
        got_div = div_start;
        if (div_start) begin
            if (div_signed) begin
                q = $signed(a) / $signed(b);
                r = $signed(a) % $signed(b);
            end else begin
                q = a / b;
                r = a % b;
            end
        end
        @(posedge clk); #1;
        ex_funct3 = 3'($urandom_range(0, 7)); ex_rs1_val = $urandom; ex_rs2_val = $urandom;
        div_done = 1'b0;
        for (int k = 1; k <= BUDGET; k++) begin
            div_done      = got_div && (k == div_lat);
            div_quotient  = div_done ? q : $urandom;
            div_remainder = div_done ? r : $urandom;
            @(negedge clk);
            if (mul_start || div_start) extra_starts++;
            if (stall) stall_n++;
            if (result_valid) begin
                rv_at = k; res = result; rv_stall = stall;
            end
            @(posedge clk); #1;
            div_done = 1'b0;
            if (rv_at >= 0) break;
        end
        ex_valid = 1'b0; ex_muldiv = 1'b0;
    endtask

    // Run one op and compare everything against the reference model.
    task automatic check_op(input string tag, input logic [2:0] f3, input logic [31:0] a,
                            input logic [31:0] b, input int div_lat);
        int stall_n, rv_at, extra;
        logic [31:0] res;
        logic t_mul, t_div, t_as, t_bs, t_ds, rv_stall;
        int exp_lat;
        logic exp_div_start;
        exp_lat = ref_latency(f3, a, b, div_lat);
        exp_div_start = f3[2] && (exp_lat != 1);
        run_mop(f3, a, b, div_lat, stall_n, rv_at, res, extra, t_mul, t_div, t_as, t_bs, t_ds, rv_stall);
        n_checks++;
        if (res !== ref_result(f3, a, b)) begin
            n_fail++; $display("FAIL %s result: got %h want %h", tag, res, ref_result(f3, a, b));
        end
        n_checks++;
        if (rv_at !== exp_lat) begin
            n_fail++; $display("FAIL %s result_valid cycle: got %0d want %0d", tag, rv_at, exp_lat);
        end
        n_checks++;
        if (stall_n !== exp_lat) begin
            n_fail++; $display("FAIL %s stall cycles: got %0d want %0d", tag, stall_n, exp_lat);
        end
        n_checks++;
        if ({t_mul, t_div, extra, rv_stall} !== {~f3[2], exp_div_start, 32'd0, 1'b0}) begin
            n_fail++; $display("FAIL %s starts: mul %b div %b extra %0d rv_stall %b want mul %b div %b extra 0 rv_stall 0",
                               tag, t_mul, t_div, extra, rv_stall, ~f3[2], exp_div_start);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; ex_valid = 1'b0; ex_muldiv = 1'b0; ex_funct3 = 3'd0; ex_rs1_val = 32'd0;
        ex_rs2_val = 32'd0; kill = 1'b0; div_done = 1'b0; div_quotient = 32'd0; div_remainder = 32'd0;
        repeat (2) @(negedge clk);
        n_checks++;
        if ({mul_start, mul_a_signed, mul_b_signed, div_start, div_signed, div_abort, stall,
             result_valid, result} !== 40'd0) begin
            n_fail++; $display("FAIL reset outputs: got stall %b rv %b result %h want all 0",
                               stall, result_valid, result);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        n_checks++;
        if ({stall, result_valid, result} !== 34'd0) begin
            n_fail++; $display("FAIL post_reset idle: got stall %b rv %b result %h want 0", stall, result_valid, result);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_mul();
        int stall_n, rv_at, extra;
        logic [31:0] res;
        logic t_mul, t_div, t_as, t_bs, t_ds, rv_stall;
        check_op("mul_7x-3", 3'd0, 32'd7, 32'hFFFF_FFFD, 0);
        n_checks++;
        if (ref_result(3'd0, 32'd7, 32'hFFFF_FFFD) !== result) begin
            n_fail++; $display("FAIL mul_hold: got %h want %h", result, 32'hFFFF_FFEB);
        end
        run_mop(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, stall_n, rv_at, res, extra, t_mul, t_div, t_as, t_bs, t_ds, rv_stall);
        n_checks++;
        if ({res, t_as, t_bs} !== {32'hFFFF_FFFE, 2'b00}) begin
            n_fail++; $display("FAIL mulhu: got %h as %b bs %b want fffffffe 0 0", res, t_as, t_bs);
        end
        run_mop(3'd2, 32'hFFFF_FFFF, 32'd5, 0, stall_n, rv_at, res, extra, t_mul, t_div, t_as, t_bs, t_ds, rv_stall);
        n_checks++;
        if ({res, t_as, t_bs} !== {32'hFFFF_FFFF, 2'b10}) begin
            n_fail++; $display("FAIL mulhsu: got %h as %b bs %b want ffffffff 1 0", res, t_as, t_bs);
        end
        run_mop(3'd1, 32'h8000_0000, 32'h8000_0000, 0, stall_n, rv_at, res, extra, t_mul, t_div, t_as, t_bs, t_ds, rv_stall);
        n_checks++;
        if ({res, t_as, t_bs} !== {32'h4000_0000, 2'b11}) begin
            n_fail++; $display("FAIL mulh: got %h as %b bs %b want 40000000 1 1", res, t_as, t_bs);
        end
    endtask

    task automatic test_div_fast();
        check_op("div_by_zero", 3'd4, 32'd100, 32'd0, 0);
        check_op("remu_by_zero", 3'd7, 32'd100, 32'd0, 0);
        check_op("div_ovf", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 0);
        check_op("rem_ovf", 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 0);
        // DIVU with the overflow operands is an ordinary divide
        check_op("divu_no_ovf", 3'd5, 32'h8000_0000, 32'hFFFF_FFFF, 4);
    endtask

    task automatic test_divide();
        int stall_n, rv_at, extra;
        logic [31:0] res;
        logic t_mul, t_div, t_as, t_bs, t_ds, rv_stall;
        run_mop(3'd5, 32'd100, 32'd7, 33, stall_n, rv_at, res, extra, t_mul, t_div, t_as, t_bs, t_ds, rv_stall);
        n_checks++;
        if ({res, stall_n, rv_at, t_div, t_ds} !== {32'd14, 32'd34, 32'd34, 1'b1, 1'b0}) begin
            n_fail++; $display("FAIL divu_100_7: got res %0d stall %0d rv_at %0d start %b signed %b want 14 34 34 1 0",
                               res, stall_n, rv_at, t_div, t_ds);
        end
        check_op("remu_100_7", 3'd7, 32'd100, 32'd7, 33);
        run_mop(3'd4, 32'hFFFF_FF9C, 32'd7, 5, stall_n, rv_at, res, extra, t_mul, t_div, t_as, t_bs, t_ds, rv_stall);
        n_checks++;
        if ({res, t_ds} !== {32'hFFFF_FFF2, 1'b1}) begin
            n_fail++; $display("FAIL div_signed: got %h signed %b want fffffff2 1", res, t_ds);
        end
        check_op("rem_signed", 3'd6, 32'hFFFF_FF9C, 32'd7, 1);
    endtask

    task automatic test_back_to_back();
        check_op("b2b_mul", 3'd0, 32'd12345, 32'd678, 0);
        check_op("b2b_div", 3'd5, 32'd1000, 32'd3, 7);
        check_op("b2b_fast", 3'd6, 32'd9, 32'd0, 0);
        check_op("b2b_mulhu", 3'd3, 32'hDEAD_BEEF, 32'h1234_5678, 0);
    endtask

    task automatic test_kill();
        logic bad;
        check_op("pre_kill", 3'd5, 32'd5, 32'd0, 0);  // result register = ffffffff
        ex_valid = 1'b1; ex_muldiv = 1'b1; ex_funct3 = 3'd5; ex_rs1_val = 32'd100; ex_rs2_val = 32'd7;
        @(negedge clk);
        n_checks++;
        if (div_start !== 1'b1) begin
            n_fail++; $display("FAIL kill_setup div_start: got %b want 1", div_start);
        end
        @(posedge clk); #1;
        ex_valid = 1'b0; ex_muldiv = 1'b0;
        bad = 1'b0;
        for (int k = 1; k < 10; k++) begin
            @(negedge clk);
            if (stall !== 1'b1) bad = 1'b1;
            @(posedge clk); #1;
        end
        n_checks++;
        if (bad) begin
            n_fail++; $display("FAIL kill_div_wait_stall: got a cycle with stall 0 want 1");
        end
        kill = 1'b1;
        @(negedge clk);
        n_checks++;
        if ({div_abort, stall, result_valid} !== 3'b100) begin
            n_fail++; $display("FAIL kill_abort: got abort %b stall %b rv %b want 1 0 0", div_abort, stall, result_valid);
        end
        @(posedge clk); #1;
        kill = 1'b0;
        div_done = 1'b0;
        bad = 1'b0;
        for (int k = 0; k < 6; k++) begin
            div_done = (k == 2); div_quotient = 32'd14; div_remainder = 32'd2;
            @(negedge clk);
            if ({mul_start, div_start, div_abort, stall, result_valid} !== 5'd0) bad = 1'b1;
            @(posedge clk); #1;
        end
        div_done = 1'b0;
        n_checks++;
        if (bad || result !== 32'hFFFF_FFFF) begin
            n_fail++; $display("FAIL kill_after: bad_outputs %b result %h want 0 ffffffff", bad, result);
        end
        // kill in the issue cycle
        ex_valid = 1'b1; ex_muldiv = 1'b1; ex_funct3 = 3'd0; kill = 1'b1;
        @(negedge clk);
        n_checks++;
        if ({mul_start, div_start, stall, result_valid} !== 4'd0) begin
            n_fail++; $display("FAIL kill_issue: got mul %b div %b stall %b rv %b want 0", mul_start, div_start, stall, result_valid);
        end
        @(posedge clk); #1;
        kill = 1'b0; ex_valid = 1'b0; ex_muldiv = 1'b0;
        bad = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if ({stall, result_valid} !== 2'd0) bad = 1'b1;
            @(posedge clk); #1;
        end
        n_checks++;
        if (bad) begin
            n_fail++; $display("FAIL kill_issue_after: got stall/result_valid activity want none");
        end
    endtask

    task automatic test_idle_gating();
        logic bad;
        bad = 1'b0;
        for (int k = 0; k < 8; k++) begin
            ex_valid = k[0]; ex_muldiv = ~k[0]; ex_funct3 = 3'($urandom_range(0, 7));
            ex_rs1_val = $urandom; ex_rs2_val = $urandom;
            @(negedge clk);
            if ({mul_start, mul_a_signed, mul_b_signed, div_start, div_signed, div_abort, stall,
                 result_valid} !== 8'd0) bad = 1'b1;
            @(posedge clk); #1;
        end
        ex_valid = 1'b0; ex_muldiv = 1'b0;
        n_checks++;
        if (bad) begin
            n_fail++; $display("FAIL idle_gating: got nonzero outputs want all 0");
        end
    endtask

    task automatic test_async_reset();
        logic bad;
        ex_valid = 1'b1; ex_muldiv = 1'b1; ex_funct3 = 3'd0; ex_rs1_val = 32'd3; ex_rs2_val = 32'd4;
        @(posedge clk); #1;
        ex_valid = 1'b0; ex_muldiv = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({mul_start, mul_a_signed, mul_b_signed, div_start, div_signed, div_abort, stall,
             result_valid, result} !== 40'd0) begin
            n_fail++; $display("FAIL async_reset: got stall %b rv %b result %h want all 0", stall, result_valid, result);
        end
        @(negedge clk);
        rst_n = 1'b1;
        bad = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if ({stall, result_valid} !== 2'd0) bad = 1'b1;
        end
        @(posedge clk); #1;
        n_checks++;
        if (bad) begin
            n_fail++; $display("FAIL async_reset_after: got stall/result_valid activity want none");
        end
        check_op("after_reset_mul", 3'd0, 32'd3, 32'd4, 0);
    endtask

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 6))
            0: return 32'd0;
            1: return 32'h8000_0000;
            2: return 32'hFFFF_FFFF;
            3: return 32'd1;
            default: return $urandom;
        endcase
    endfunction

    task automatic test_random();
        for (int n = 0; n < 40; n++) begin
            check_op("random", 3'($urandom_range(0, 7)), pick_operand(), pick_operand(),
                     $urandom_range(1, 40));
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_mul();
        test_div_fast();
        test_divide();
        test_back_to_back();
        test_kill();
        test_idle_gating();
        test_async_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end

endmodule
